// File: rtl/seq_restoring_divider.sv
// Sequential 6-bit by 3-bit unsigned restoring divider, one quotient bit per RUN cycle.
// Optional macro DIV_ZERO_FLAG_EN: a zero divisor skips RUN and raises div_by_zero.
module seq_restoring_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] dividend,
  input  logic [2:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [5:0] quotient,
  output logic [2:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [5:0] dvd_r;
  logic [2:0] dvs_r;
  logic [3:0] part;
  logic [4:0] q_r;
  logic [2:0] cnt;

  logic [3:0] shifted;
  logic [4:0] diff;
  logic       q_bit;
  logic [3:0] part_n;

  // One restoring step: shift in the next dividend bit, trial-subtract, restore on borrow.
  always_comb begin
    shifted = {part[2:0], dvd_r[5]};
    diff    = {1'b0, shifted} - {2'b00, dvs_r};
    q_bit   = ~diff[4];
    part_n  = q_bit ? diff[3:0] : shifted;
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_r;
  assign div_by_zero = dz_r;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_r     <= '0;
      dvs_r     <= '0;
      part      <= '0;
      q_r       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_r      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            part  <= '0;
            q_r   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            if (divisor == 3'd0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              dz_r      <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          part  <= part_n;
          dvd_r <= {dvd_r[4:0], 1'b0};
          q_r   <= {q_r[3:0], q_bit};
          cnt   <= cnt + 3'd1;
          // Last step: results are taken from this cycle's step, not the registers.
          if (cnt == 3'd5) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= {q_r, q_bit};
            remainder <= part_n[2:0];
`ifdef DIV_ZERO_FLAG_EN
            dz_r      <= 1'b0;
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: scoreboard of expected results checked on each done pulse.
// Follows DIV_ZERO_FLAG_EN the same way the design does.
module tb_seq_restoring_divider;

`ifdef DIV_ZERO_FLAG_EN
  localparam bit FLAG = 1'b1;
`else
  localparam bit FLAG = 1'b0;
`endif
  localparam int PERIOD = 10;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  seq_restoring_divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    logic [5:0] q;
    logic [2:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  time  done_tq[$];
  int   passed = 0;
  int   total = 0;
  int   done_cnt = 0;
  time  done_t = 0;
  time  acc_t = 0;

  function automatic void chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endfunction

  function automatic void push_exp(logic [5:0] a, logic [2:0] b);
    exp_t e;
    if (b == 3'd0) begin
      e.q  = 6'h3F;
      e.r  = FLAG ? 3'd0 : a[2:0];
      e.dz = FLAG;
    end else begin
      e.q  = a / {3'b000, b};
      e.r  = 3'(a % {3'b000, b});
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      done_t = $time;
      done_tq.push_back($time);
      chk("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("quotient", int'(quotient), int'(e.q));
        chk("remainder", int'(remainder), int'(e.r));
        chk("div_by_zero", int'(div_by_zero), int'(e.dz));
      end
    end
  end

  task automatic run_op(input logic [5:0] a, input logic [2:0] b, input bit glitch);
    int d0;
    int exp_edges;
    bit busy_ok;
    exp_edges = (b == 3'd0 && FLAG) ? 0 : 6;
    push_exp(a, b);
    @(negedge clk);
    d0       = done_cnt;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    start    = 1'b0;
    dividend = 6'($urandom_range(63));
    divisor  = 3'($urandom_range(7));
    #1;
    busy_ok = 1'b1;
    for (int i = 0; i < 20 && done_cnt == d0; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (glitch && i == 1) begin
        start    = 1'b1;
        dividend = 6'd50;
        divisor  = 3'd5;
      end
      if (glitch && i == 2) start = 1'b0;
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    chk("done_seen", done_cnt - d0, 1);
    chk("latency_edges", int'((done_t - acc_t) / PERIOD), exp_edges);
    chk("busy_during_run", int'(busy_ok), 1);
    chk("busy_in_done", int'(busy), 1);
    @(negedge clk);
    #1;
    chk("done_single_pulse", int'(done), 0);
    chk("busy_after_done", int'(busy), 0);
    if (glitch) begin
      repeat (12) @(negedge clk);
      #1;
      chk("no_queued_start", done_cnt - d0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int d0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    rst = 1'b0;

    run_op(6'd45, 3'd6, 1'b0);
    run_op(6'd63, 3'd1, 1'b0);
    run_op(6'd63, 3'd7, 1'b0);
    run_op(6'd5, 3'd7, 1'b0);
    run_op(6'd0, 3'd3, 1'b0);
    run_op(6'd20, 3'd3, 1'b1);

    // Abort 45/6 with reset sampled at the end of the third RUN cycle.
    @(negedge clk);
    d0       = done_cnt;
    dividend = 6'd45;
    divisor  = 3'd6;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);

    run_op(6'd12, 3'd4, 1'b0);
    run_op(6'd13, 3'd0, 1'b0);

    // Start held high across three back-to-back operations.
    done_tq.delete();
    push_exp(6'd45, 3'd6);
    push_exp(6'd50, 3'd7);
    push_exp(6'd33, 3'd2);
    @(negedge clk);
    d0       = done_cnt;
    start    = 1'b1;
    dividend = 6'd45;
    divisor  = 3'd6;
    @(posedge clk);
    @(negedge clk);
    dividend = 6'd50;
    divisor  = 3'd7;
    repeat (8) @(posedge clk);
    @(negedge clk);
    dividend = 6'd33;
    divisor  = 3'd2;
    repeat (8) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30 && done_cnt < d0 + 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("b2b_done_count", done_cnt - d0, 3);
    if (done_tq.size() == 3) begin
      chk("b2b_spacing_1", int'((done_tq[1] - done_tq[0]) / PERIOD), 8);
      chk("b2b_spacing_2", int'((done_tq[2] - done_tq[1]) / PERIOD), 8);
    end

    for (int k = 0; k < 4; k++)
      run_op(6'($urandom_range(63)), 3'($urandom_range(7)), 1'b0);
    run_op(6'd37, 3'd0, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
